// File: rtl/solo_squash_input_conditioner.sv
// Input conditioner for the solo_squash GPIO buttons and external reset.
// Every raw active-low input passes through a 2-FF synchronizer and a
// per-channel debouncer. All outputs stay inactive until firmware signals,
// via gpio_ready, that the GPIO pads are configured.
module solo_squash_input_conditioner #(
    parameter int unsigned DEBOUNCE_LEN = 50000,
    parameter int unsigned CNT_W        = $clog2(DEBOUNCE_LEN)
) (
    input  logic clk,
    input  logic reset,
    input  logic gpio_ready,
    input  logic ext_reset_n_raw,
    input  logic pause_n_raw,
    input  logic new_game_n_raw,
    input  logic down_key_n_raw,
    input  logic up_key_n_raw,
    output logic ext_reset_n,
    output logic pause_n,
    output logic new_game_n,
    output logic down_key_n,
    output logic up_key_n,
    output logic pause_press,
    output logic new_game_press,
    output logic armed
);

    localparam int unsigned NUM_CH   = 5;
    localparam int unsigned CH_EXT   = 0;
    localparam int unsigned CH_PAUSE = 1;
    localparam int unsigned CH_NEW   = 2;
    localparam int unsigned CH_DOWN  = 3;
    localparam int unsigned CH_UP    = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] clean;
    logic [NUM_CH-1:0] clean_nxt;
    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
    logic              gpio_sync1;
    logic              gpio_sync2;

    assign raw = {up_key_n_raw, down_key_n_raw, new_game_n_raw,
                  pause_n_raw, ext_reset_n_raw};

    // Two-flop synchronizers: raw inputs idle high, gpio_ready idles low.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '1;
            sync2      <= '1;
            gpio_sync1 <= 1'b0;
            gpio_sync2 <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            gpio_sync1 <= gpio_ready;
            gpio_sync2 <= gpio_sync1;
        end
    end

    // Sticky arm flag: once GPIOs are reported ready, later drops are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (gpio_sync2) begin
            armed <= 1'b1;
        end
    end

    // Debounce next-state: the ext_reset channel asserts immediately, all
    // other transitions need DEBOUNCE_LEN consecutive mismatching cycles.
    always_comb begin
        clean_nxt = clean;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = '0;
        end
        if (!armed) begin
            clean_nxt = '1;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (i == CH_EXT && !sync2[i]) begin
                    clean_nxt[i] = 1'b0;
                end else if (sync2[i] != clean[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        clean_nxt[i] = sync2[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    // Debounce state and registered press pulses on clean 1->0 transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            clean          <= '1;
            pause_press    <= 1'b0;
            new_game_press <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            clean          <= clean_nxt;
            pause_press    <= clean[CH_PAUSE] & ~clean_nxt[CH_PAUSE];
            new_game_press <= clean[CH_NEW] & ~clean_nxt[CH_NEW];
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign ext_reset_n = clean[CH_EXT];
    assign pause_n     = clean[CH_PAUSE];
    assign new_game_n  = clean[CH_NEW];
    assign down_key_n  = clean[CH_DOWN];
    assign up_key_n    = clean[CH_UP];

endmodule

// File: doc/solo_squash_input_conditioner.md
# solo_squash_input_conditioner

Input conditioning stage between the raw GPIO inputs (IO[12:8]) and the Caravel-facing solo_squash wrapper. Every active-low button and the external reset pass through a 2-FF synchronizer and a per-channel debouncer. Clean levels and single-cycle press pulses are produced. All outputs are held inactive until firmware signals GPIO setup is complete via gpio_ready, so indeterminate pad values before GPIO init can never reset or steer the game.

## Interface

Parameters:
- DEBOUNCE_LEN, default 50000: consecutive synchronized cycles a new level must persist before the clean output follows it (2 ms at 25 MHz). Minimum 2.
- CNT_W, default $clog2(DEBOUNCE_LEN): debounce counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  design clock (wb_clk_i)
- reset  in  1  synchronous, active-high (wb_rst_i)
- gpio_ready  in  1  firmware "GPIOs configured" level (la_data_in[32]); asynchronous to logic, synchronized internally
- ext_reset_n_raw, pause_n_raw, new_game_n_raw, down_key_n_raw, up_key_n_raw  in  1 each  raw pad inputs, active-low
- ext_reset_n, pause_n, new_game_n, down_key_n, up_key_n  out  1 each  conditioned active-low levels
- pause_press, new_game_press  out  1 each  one-cycle pulse on the debounced press (1->0) of that button
- armed  out  1  high once gpio_ready has been seen

## Operation

- Synchronizers:
  - Each raw input has a 2-FF chain (s1, s2); it reset to 1 and always runs.
  - gpio_ready has its own 2-FF chain that resets to 0.
- Arming:
  - armed resets to 0.
  - It sets on the edge where synchronized gpio_ready is 1, then stays 1 until reset. Later gpio_ready deassertion is ignored.
- While armed=0:
  - All clean outputs are forced to 1, pulses to 0, counters to 0.
- Debouncer, button channels (pause, new_game, down, up), when armed=1:
  - If s2 == clean: counter <= 0.
  - If s2 != clean and counter != DEBOUNCE_LEN-1: counter <= counter+1.
  - If s2 != clean and counter == DEBOUNCE_LEN-1: clean <= s2, counter <= 0.
  - Any mismatch run shorter than DEBOUNCE_LEN cycles leaves clean unchanged. The counter never overflows.
- ext_reset_n channel, asymmetric:
  - Assertion is fast: if s2 == 0, clean <= 0 on that edge, counter <= 0.
  - Release (0->1) uses the debounce rule above.
- Press pulses:
  - pause_press / new_game_press are registered.
  - Each is 1 for exactly the cycle after the edge on which its clean level goes 1->0, otherwise 0.
  - Releases do not pulse.
- Channels are fully independent. Simultaneous transitions on several inputs are each processed in parallel, with no priority.

## Timing

- Reset values: ext_reset_n/pause_n/new_game_n/down_key_n/up_key_n = 1; pause_press = new_game_press = 0; armed = 0; all counters 0; raw syncs 1; gpio_ready sync 0.
- Reset asserted mid-operation: every output returns to its reset value on the same edge, and any in-progress debounce count is discarded.
- Arming latency: gpio_ready first sampled high at edge 0 -> armed = 1 after edge 2.
- Debounce latency: new raw level first sampled at edge 0 -> s2 valid after edge 1 -> clean updates at edge DEBOUNCE_LEN+1. The press pulse is high for the cycle following edge DEBOUNCE_LEN+1.
- ext_reset_n assertion latency: raw low sampled at edge 0 -> output 0 after edge 2 (when armed).
- A raw input already low at arming is debounced from the arming edge; the clean value follows DEBOUNCE_LEN cycles after armed rises.

## Test plan

(DEBOUNCE_LEN = 4 throughout)

- Reset then idle with gpio_ready = 0 and all raw inputs 0 for 20 cycles -> all *_n outputs stay 1, pulses 0, armed 0.
- gpio_ready rises (sampled at edge 0) -> armed = 1 after edge 2. gpio_ready later drops -> armed stays 1 until reset.
- Armed; new_game_n_raw 1->0 held, first sampled at edge 0 -> new_game_n = 0 after edge 5; new_game_press = 1 for exactly one cycle after edge 5. Release held -> new_game_n = 1 after 5 more edges, no pulse.
- Armed; pause_n_raw low for 3 cycles then high (glitch) -> pause_n stays 1, pause_press never pulses. Low for 4+ cycles -> one pulse.
- Armed; ext_reset_n_raw low at edge 0 -> ext_reset_n = 0 after edge 2. Raw high with a 2-cycle low bounce in the middle -> ext_reset_n rises only 5 edges after the last bounce ends.
- up_key_n_raw and down_key_n_raw fall on the same edge; reset asserted at the edge where their counters equal 2 -> both outputs stay 1, counters 0, armed 0 on the next cycle.
